// File: rtl/usb_boot_sequencer_if.sv
// Bundle of the boot sequencer's board-facing signals: PLL lock, boot request and warmboot/USB outputs.
// slave = the sequencer itself, master = whatever drives lock and boot requests.
interface usb_boot_sequencer_if #(
    parameter int NUM_IMAGES = 4
);
    localparam int IMG_W = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;

    logic             pll_lock;
    logic             boot_req;
    logic [IMG_W-1:0] boot_image;
    logic             core_reset;
    logic             clk_en;
    logic             usb_pu;
    logic             wb_s1;
    logic             wb_s0;
    logic             wb_boot;
    logic             busy;
    logic             boot_err;

    modport slave (
        input  pll_lock, boot_req, boot_image,
        output core_reset, clk_en, usb_pu, wb_s1, wb_s0, wb_boot, busy, boot_err
    );

    modport master (
        output pll_lock, boot_req, boot_image,
        input  core_reset, clk_en, usb_pu, wb_s1, wb_s0, wb_boot, busy, boot_err
    );
endinterface

// File: rtl/usb_boot_sequencer.sv
// Power-up/boot sequencer: PLL lock qualification, core reset release, clk_en strobe, USB detach, warmboot.
// Build option USB_BOOT_SEQ_DETACH_EN: when undefined, DETACH becomes a fixed 2-cycle SETUP with usb_pu kept high.
//
// state     | meaning
// WAIT_LOCK | core held in reset, counting consecutive synced-lock cycles
// RUN       | core running, clk_en strobing, boot requests accepted
// DETACH    | image latched, USB pull-up dropped (or short SETUP), counting down to warmboot
// BOOT      | wb_boot asserted, terminal until reset
module usb_boot_sequencer #(
    parameter int NUM_IMAGES         = 4,
    parameter int LOCK_STABLE_CYCLES = 4800,
    parameter int DETACH_CYCLES      = 480000,
    parameter int CLKEN_DIV          = 4
) (
    input logic                clk_48mhz,
    input logic                reset_n,
    usb_boot_sequencer_if.slave bus
);
    localparam int IMG_W  = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
    localparam int IMGX_W = IMG_W + 1;
    localparam int MAX_C  = (LOCK_STABLE_CYCLES > DETACH_CYCLES) ? LOCK_STABLE_CYCLES : DETACH_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C + 1);
    localparam int DIV_W  = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;

`ifdef USB_BOOT_SEQ_DETACH_EN
    localparam int   DET_LEN   = DETACH_CYCLES;
    localparam logic DETACH_PU = 1'b0;
`else
    localparam int   DET_LEN   = 2;
    localparam logic DETACH_PU = 1'b1;
`endif

    localparam logic [CNT_W-1:0]  LOCK_TC   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DET_TC    = CNT_W'(DET_LEN - 1);
    localparam logic [DIV_W-1:0]  DIV_TC    = DIV_W'(CLKEN_DIV - 1);
    localparam logic [IMGX_W-1:0] NUM_IMG_X = IMGX_W'(NUM_IMAGES);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RUN       = 2'd1,
        DETACH    = 2'd2,
        BOOT      = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             lock_m, lock_s;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div, div_nxt;
    logic [1:0]       wb_s, wb_s_nxt;
    logic             core_reset_r, core_reset_nxt;
    logic             clk_en_r, clk_en_nxt;
    logic             usb_pu_r, usb_pu_nxt;
    logic             wb_boot_r, wb_boot_nxt;
    logic             busy_r, busy_nxt;
    logic             boot_err_r, boot_err_nxt;
    logic             img_ok;

    assign img_ok = ({1'b0, bus.boot_image} < NUM_IMG_X);

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            lock_m       <= 1'b0;
            lock_s       <= 1'b0;
            state        <= WAIT_LOCK;
            cnt          <= '0;
            div          <= '0;
            wb_s         <= 2'b00;
            core_reset_r <= 1'b1;
            clk_en_r     <= 1'b0;
            usb_pu_r     <= 1'b0;
            wb_boot_r    <= 1'b0;
            busy_r       <= 1'b1;
            boot_err_r   <= 1'b0;
        end else begin
            lock_m       <= bus.pll_lock;
            lock_s       <= lock_m;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            div          <= div_nxt;
            wb_s         <= wb_s_nxt;
            core_reset_r <= core_reset_nxt;
            clk_en_r     <= clk_en_nxt;
            usb_pu_r     <= usb_pu_nxt;
            wb_boot_r    <= wb_boot_nxt;
            busy_r       <= busy_nxt;
            boot_err_r   <= boot_err_nxt;
        end
    end

    // Outputs are computed for the next state so they change on the same edge as the state register.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        div_nxt        = div;
        wb_s_nxt       = wb_s;
        core_reset_nxt = core_reset_r;
        clk_en_nxt     = 1'b0;
        usb_pu_nxt     = usb_pu_r;
        wb_boot_nxt    = wb_boot_r;
        busy_nxt       = busy_r;
        boot_err_nxt   = 1'b0;

        case (state)
            WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_nxt = '0;
                end else if (cnt == LOCK_TC) begin
                    state_nxt      = RUN;
                    cnt_nxt        = '0;
                    div_nxt        = '0;
                    core_reset_nxt = 1'b0;
                    usb_pu_nxt     = 1'b1;
                    busy_nxt       = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt      = WAIT_LOCK;
                    cnt_nxt        = '0;
                    core_reset_nxt = 1'b1;
                    usb_pu_nxt     = 1'b0;
                    busy_nxt       = 1'b1;
                end else if (bus.boot_req && img_ok) begin
                    state_nxt      = DETACH;
                    cnt_nxt        = '0;
                    wb_s_nxt       = 2'(bus.boot_image);
                    core_reset_nxt = 1'b1;
                    usb_pu_nxt     = DETACH_PU;
                    busy_nxt       = 1'b1;
                end else begin
                    boot_err_nxt = bus.boot_req;
                    clk_en_nxt   = (div == DIV_TC);
                    div_nxt      = (div == DIV_TC) ? '0 : div + 1'b1;
                end
            end
            DETACH: begin
                // Image select was latched on entry, so it is stable for DET_LEN (>=2) cycles before wb_boot.
                if (cnt == DET_TC) begin
                    state_nxt   = BOOT;
                    wb_boot_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            BOOT: begin
                wb_boot_nxt = 1'b1;
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
    end

    assign bus.core_reset = core_reset_r;
    assign bus.clk_en     = clk_en_r;
    assign bus.usb_pu     = usb_pu_r;
    assign bus.wb_s1      = wb_s[1];
    assign bus.wb_s0      = wb_s[0];
    assign bus.wb_boot    = wb_boot_r;
    assign bus.busy       = busy_r;
    assign bus.boot_err   = boot_err_r;
endmodule

// File: tb/tb_usb_boot_sequencer.sv
// Directed bench: two sequencer instances (main build and a 3-image, CLKEN_DIV=1 build) on one clock.
module tb_usb_boot_sequencer;
    logic clk_48mhz = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk_48mhz = ~clk_48mhz;

`ifdef USB_BOOT_SEQ_DETACH_EN
    localparam int   DLEN   = 16;
    localparam logic PU_DET = 1'b0;
`else
    localparam int   DLEN   = 2;
    localparam logic PU_DET = 1'b1;
`endif

    usb_boot_sequencer_if #(.NUM_IMAGES(4)) bus_a ();
    usb_boot_sequencer_if #(.NUM_IMAGES(3)) bus_b ();

    usb_boot_sequencer #(
        .NUM_IMAGES(4), .LOCK_STABLE_CYCLES(8), .DETACH_CYCLES(16), .CLKEN_DIV(4)
    ) dut_a (
        .clk_48mhz(clk_48mhz), .reset_n(reset_n), .bus(bus_a)
    );

    usb_boot_sequencer #(
        .NUM_IMAGES(3), .LOCK_STABLE_CYCLES(8), .DETACH_CYCLES(16), .CLKEN_DIV(1)
    ) dut_b (
        .clk_48mhz(clk_48mhz), .reset_n(reset_n), .bus(bus_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk_48mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        bus_a.pll_lock   = 1'b0;
        bus_a.boot_req   = 1'b0;
        bus_a.boot_image = '0;
        bus_b.pll_lock   = 1'b0;
        bus_b.boot_req   = 1'b0;
        bus_b.boot_image = '0;
        tick(3);

        chk("rst_core_reset", bus_a.core_reset, 1'b1);
        chk("rst_busy",       bus_a.busy,       1'b1);
        chk("rst_clk_en",     bus_a.clk_en,     1'b0);
        chk("rst_usb_pu",     bus_a.usb_pu,     1'b0);
        chk("rst_wb_s1",      bus_a.wb_s1,      1'b0);
        chk("rst_wb_s0",      bus_a.wb_s0,      1'b0);
        chk("rst_wb_boot",    bus_a.wb_boot,    1'b0);
        chk("rst_boot_err",   bus_a.boot_err,   1'b0);

        // 2 sync edges + 8 qualifying edges before RUN
        reset_n        = 1'b1;
        bus_a.pll_lock = 1'b1;
        bus_b.pll_lock = 1'b1;
        tick(9);
        chk("lock_busy_pre",       bus_a.busy,       1'b1);
        chk("lock_core_reset_pre", bus_a.core_reset, 1'b1);
        tick(1);
        chk("run_busy",       bus_a.busy,       1'b0);
        chk("run_core_reset", bus_a.core_reset, 1'b0);
        chk("run_usb_pu",     bus_a.usb_pu,     1'b1);
        chk("run_clk_en_entry", bus_a.clk_en,   1'b0);
        chk("run_b_busy",     bus_b.busy,       1'b0);

        for (int i = 1; i <= 8; i++) begin
            tick(1);
            chk("clk_en_div4", bus_a.clk_en, (i % 4) == 0);
            chk("clk_en_div1", bus_b.clk_en, 1'b1);
        end

        bus_b.boot_req   = 1'b1;
        bus_b.boot_image = 2'd3;
        tick(1);
        bus_b.boot_req   = 1'b0;
        bus_b.boot_image = 2'd0;
        chk("err_pulse",   bus_b.boot_err, 1'b1);
        chk("err_busy",    bus_b.busy,     1'b0);
        chk("err_wb_s1",   bus_b.wb_s1,    1'b0);
        chk("err_wb_s0",   bus_b.wb_s0,    1'b0);
        tick(1);
        chk("err_one_cycle", bus_b.boot_err, 1'b0);
        chk("err_stay_run",  bus_b.busy,     1'b0);

        bus_a.boot_req   = 1'b1;
        bus_a.boot_image = 2'd2;
        tick(1);
        bus_a.boot_req   = 1'b0;
        bus_a.boot_image = 2'd0;
        chk("det_wb_s1",      bus_a.wb_s1,      1'b1);
        chk("det_wb_s0",      bus_a.wb_s0,      1'b0);
        chk("det_core_reset", bus_a.core_reset, 1'b1);
        chk("det_busy",       bus_a.busy,       1'b1);
        chk("det_clk_en",     bus_a.clk_en,     1'b0);
        chk("det_usb_pu",     bus_a.usb_pu,     PU_DET);
        chk("det_wb_boot",    bus_a.wb_boot,    1'b0);
        bus_a.pll_lock = 1'b0;
        for (int t = 2; t <= DLEN; t++) begin
            tick(1);
            chk("det_wb_boot_low", bus_a.wb_boot, 1'b0);
            chk("det_usb_pu_hold", bus_a.usb_pu,  PU_DET);
        end
        tick(1);
        chk("boot_wb_boot", bus_a.wb_boot, 1'b1);
        chk("boot_wb_s1",   bus_a.wb_s1,   1'b1);
        chk("boot_wb_s0",   bus_a.wb_s0,   1'b0);
        chk("boot_usb_pu",  bus_a.usb_pu,  PU_DET);
        chk("boot_busy",    bus_a.busy,    1'b1);
        bus_a.boot_req = 1'b1;
        tick(3);
        bus_a.boot_req = 1'b0;
        chk("boot_held", bus_a.wb_boot, 1'b1);

        bus_a.pll_lock = 1'b1;
        reset_n        = 1'b0;
        tick(1);
        chk("boot_reset_wb_boot", bus_a.wb_boot, 1'b0);
        chk("boot_reset_wb_s1",   bus_a.wb_s1,   1'b0);
        reset_n = 1'b1;
        tick(10);
        chk("rerun_busy", bus_a.busy, 1'b0);
        bus_a.boot_req   = 1'b1;
        bus_a.boot_image = 2'd1;
        tick(1);
        bus_a.boot_req   = 1'b0;
        bus_a.boot_image = 2'd0;
        chk("det2_wb_s0", bus_a.wb_s0, 1'b1);
        tick(1);
        reset_n = 1'b0;
        tick(1);
        chk("midrst_wb_s0",      bus_a.wb_s0,      1'b0);
        chk("midrst_wb_s1",      bus_a.wb_s1,      1'b0);
        chk("midrst_core_reset", bus_a.core_reset, 1'b1);
        chk("midrst_busy",       bus_a.busy,       1'b1);
        chk("midrst_usb_pu",     bus_a.usb_pu,     1'b0);
        chk("midrst_wb_boot",    bus_a.wb_boot,    1'b0);

        // Lock glitch at count 5; qualification restarts, RUN 8 edges after lock_s returns
        reset_n = 1'b1;
        tick(5);
        bus_a.pll_lock = 1'b0;
        tick(1);
        bus_a.pll_lock = 1'b1;
        tick(9);
        chk("glitch_busy_pre", bus_a.busy, 1'b1);
        tick(1);
        chk("glitch_run", bus_a.busy, 1'b0);

        bus_a.pll_lock = 1'b0;
        tick(2);
        chk("drop_still_run", bus_a.busy, 1'b0);
        bus_a.boot_req   = 1'b1;
        bus_a.boot_image = 2'd2;
        tick(1);
        bus_a.boot_req   = 1'b0;
        bus_a.boot_image = 2'd0;
        chk("drop_busy",       bus_a.busy,       1'b1);
        chk("drop_core_reset", bus_a.core_reset, 1'b1);
        chk("drop_usb_pu",     bus_a.usb_pu,     1'b0);
        chk("drop_wb_s1",      bus_a.wb_s1,      1'b0);
        chk("drop_boot_err",   bus_a.boot_err,   1'b0);
        chk("drop_clk_en",     bus_a.clk_en,     1'b0);
        tick(DLEN + 2);
        chk("drop_no_boot", bus_a.wb_boot, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
